// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS sweep sequencer and its register block.
package dds_pkg;

  localparam int FTW_WIDTH = 32;

  // FTW per Hz in Q16 for a 250 MHz DDS sample clock: ftw = (hz * FTW_PER_HZ_Q16) >> 16
  localparam longint unsigned DDS_FS_HZ      = 64'd250_000_000;
  localparam longint unsigned FTW_PER_HZ_Q16 = (64'd1 << (FTW_WIDTH + 16)) / DDS_FS_HZ;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_WAIT_ACK,
    ST_STEP,
    ST_DONE
  } sweep_state_t;

endpackage

// File: rtl/dds_sweep_timer.sv
// Phase timer: clearable counter with qualified increment and a loadable terminal value.
// tc is combinational from the registered count and term; clr takes priority over inc.
module dds_sweep_timer #(
  parameter int CNT_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  input  logic                 ld,
  input  logic [CNT_WIDTH-1:0] ld_term,
  output logic                 tc
);

  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] term_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      term_q <= '0;
    end else begin
      if (ld) term_q <= ld_term;
      if (clr)      cnt <= '0;
      else if (inc) cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == term_q);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the DDS FTW over equally spaced points with settle,
// measurement window and ack handshake per point. All outputs registered; abort returns to IDLE.
module dds_sweep_ctrl #(
  parameter int FTW_WIDTH = dds_pkg::FTW_WIDTH,
  parameter int CNT_WIDTH = 24,
  parameter int IDX_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [FTW_WIDTH-1:0] i_ftw_start,
  input  logic [FTW_WIDTH-1:0] i_ftw_step,
  input  logic [IDX_WIDTH-1:0] i_num_points,
  input  logic [CNT_WIDTH-1:0] i_settle_cycles,
  input  logic [CNT_WIDTH-1:0] i_dwell_cycles,
  input  logic                 i_dds_valid,
  input  logic                 i_result_ack,
  output logic [FTW_WIDTH-1:0] o_dds_ftw,
  output logic                 o_meas_en,
  output logic [IDX_WIDTH-1:0] o_point_idx,
  output logic                 o_point_done,
  output logic                 o_busy,
  output logic                 o_done
);

  import dds_pkg::*;

  sweep_state_t state, state_nxt;

  logic [FTW_WIDTH-1:0] step_q;
  logic [IDX_WIDTH-1:0] num_q;
  logic [CNT_WIDTH-1:0] settle_q;
  logic [CNT_WIDTH-1:0] dwell_q;

  logic                 tmr_clr, tmr_inc, tmr_ld, tmr_tc;
  logic [CNT_WIDTH-1:0] tmr_term;
  logic [CNT_WIDTH-1:0] settle_src;
  logic                 last_pt;

  logic [FTW_WIDTH-1:0] ftw_d;
  logic [IDX_WIDTH-1:0] idx_d;
  logic                 meas_d, pd_d, busy_d, done_d;

  assign last_pt = (o_point_idx == num_q - IDX_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (i_abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     if (i_start) state_nxt = (i_num_points == '0) ? ST_DONE : ST_SETTLE;
        ST_SETTLE:   if (settle_q == '0 || (i_dds_valid && tmr_tc)) state_nxt = ST_MEASURE;
        ST_MEASURE:  if (tmr_tc) state_nxt = ST_WAIT_ACK;
        ST_WAIT_ACK: if (i_result_ack) state_nxt = last_pt ? ST_DONE : ST_STEP;
        ST_STEP:     state_nxt = ST_SETTLE;
        ST_DONE:     state_nxt = ST_IDLE;
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

  // Timer restarts on every phase change; the terminal value is loaded alongside.
  always_comb begin
    settle_src = (state == ST_IDLE) ? i_settle_cycles : settle_q;
    tmr_clr    = (state_nxt != state);
    tmr_ld     = tmr_clr;
    tmr_inc    = (state == ST_SETTLE && i_dds_valid) || (state == ST_MEASURE);
    if (state_nxt == ST_MEASURE)
      tmr_term = (dwell_q == '0) ? '0 : dwell_q - 1'b1;
    else
      tmr_term = (settle_src == '0) ? '0 : settle_src - 1'b1;
  end

  dds_sweep_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .inc     (tmr_inc),
    .ld      (tmr_ld),
    .ld_term (tmr_term),
    .tc      (tmr_tc)
  );

  always_comb begin
    ftw_d  = o_dds_ftw;
    idx_d  = o_point_idx;
    if (state == ST_IDLE && state_nxt == ST_SETTLE) begin
      ftw_d = i_ftw_start;
      idx_d = '0;
    end else if (state == ST_STEP && state_nxt == ST_SETTLE) begin
      ftw_d = o_dds_ftw + step_q;
      idx_d = o_point_idx + IDX_WIDTH'(1);
    end
    meas_d = (state_nxt == ST_MEASURE);
    pd_d   = (state_nxt == ST_WAIT_ACK);
    busy_d = (state_nxt == ST_SETTLE) || (state_nxt == ST_MEASURE) ||
             (state_nxt == ST_WAIT_ACK) || (state_nxt == ST_STEP);
    done_d = (state_nxt == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_dds_ftw    <= '0;
      o_point_idx  <= '0;
      o_meas_en    <= 1'b0;
      o_point_done <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      step_q       <= '0;
      num_q        <= '0;
      settle_q     <= '0;
      dwell_q      <= '0;
    end else begin
      o_dds_ftw    <= ftw_d;
      o_point_idx  <= idx_d;
      o_meas_en    <= meas_d;
      o_point_done <= pd_d;
      o_busy       <= busy_d;
      o_done       <= done_d;
      if (state == ST_IDLE && state_nxt != ST_IDLE) begin
        step_q   <= i_ftw_step;
        num_q    <= i_num_points;
        settle_q <= i_settle_cycles;
        dwell_q  <= i_dwell_cycles;
      end
    end
  end

endmodule
